// File: rtl/axi4_lite_arbiter.sv
// Two-master to one-slave AXI4-Lite arbiter: round-robin between masters, writes before reads
// within a master, one transaction outstanding, responses passed through combinationally.
module axi4_lite_arbiter #(
  parameter int NUM_M      = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [NUM_M*ADDR_WIDTH-1:0]   s_awaddr,
  input  logic [NUM_M*ADDR_WIDTH-1:0]   s_araddr,
  input  logic [NUM_M*3-1:0]            s_awprot,
  input  logic [NUM_M*3-1:0]            s_arprot,
  input  logic [NUM_M-1:0]              s_awvalid,
  input  logic [NUM_M-1:0]              s_wvalid,
  input  logic [NUM_M-1:0]              s_arvalid,
  input  logic [NUM_M-1:0]              s_bready,
  input  logic [NUM_M-1:0]              s_rready,
  input  logic [NUM_M*DATA_WIDTH-1:0]   s_wdata,
  input  logic [NUM_M*DATA_WIDTH/8-1:0] s_wstrb,
  output logic [NUM_M-1:0]              s_awready,
  output logic [NUM_M-1:0]              s_wready,
  output logic [NUM_M-1:0]              s_arready,
  output logic [NUM_M-1:0]              s_bvalid,
  output logic [NUM_M-1:0]              s_rvalid,
  output logic [NUM_M*2-1:0]            s_bresp,
  output logic [NUM_M*2-1:0]            s_rresp,
  output logic [NUM_M*DATA_WIDTH-1:0]   s_rdata,
  output logic [ADDR_WIDTH-1:0]         m_awaddr,
  output logic [ADDR_WIDTH-1:0]         m_araddr,
  output logic [2:0]                    m_awprot,
  output logic [2:0]                    m_arprot,
  output logic [DATA_WIDTH-1:0]         m_wdata,
  output logic [DATA_WIDTH/8-1:0]       m_wstrb,
  output logic                          m_awvalid,
  output logic                          m_wvalid,
  output logic                          m_arvalid,
  output logic                          m_bready,
  output logic                          m_rready,
  input  logic                          m_awready,
  input  logic                          m_wready,
  input  logic                          m_arready,
  input  logic                          m_bvalid,
  input  logic                          m_rvalid,
  input  logic [1:0]                    m_bresp,
  input  logic [1:0]                    m_rresp,
  input  logic [DATA_WIDTH-1:0]         m_rdata
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr, gnt, pick, gnt_inc;
  logic            found;
  logic            aw_done, w_done;
  logic            aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [NUM_M-1:0] req;
  int              gi;

  // A channel transfers on the rising edge where its valid and ready are both high; valid,
  // once raised by the source, is held with stable payload until that edge.
  assign aw_hs   = m_awvalid & m_awready;
  assign w_hs    = m_wvalid & m_wready;
  assign b_hs    = m_bvalid & m_bready;
  assign ar_hs   = m_arvalid & m_arready;
  assign r_hs    = m_rvalid & m_rready;
  assign req     = s_awvalid | s_arvalid;
  assign gi      = int'(gnt);
  assign gnt_inc = (gnt == IW'(NUM_M - 1)) ? '0 : gnt + IW'(1);

  // First requester at or after the round-robin pointer wins.
  always_comb begin
    int            idx;
    logic [IW-1:0] idx_b;
    pick  = rr_ptr;
    found = 1'b0;
    idx   = 0;
    idx_b = '0;
    for (int k = 0; k < NUM_M; k++) begin
      idx   = (int'(rr_ptr) + k) % NUM_M;
      idx_b = IW'(idx);
      if (!found && req[idx_b]) begin
        found = 1'b1;
        pick  = idx_b;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      gnt     <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && found) gnt <= pick;
      if (state == WR_ADDR) begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      if (b_hs) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (b_hs || r_hs) rr_ptr <= gnt_inc;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = s_awvalid[pick] ? WR_ADDR : RD_ADDR;
      WR_ADDR: if ((aw_done | aw_hs) && (w_done | w_hs)) state_nxt = WR_RESP;
      WR_RESP: if (b_hs) state_nxt = IDLE;
      RD_ADDR: if (ar_hs) state_nxt = RD_DATA;
      RD_DATA: if (r_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Only the granted master's slice is ever driven; everything else stays at zero.
  always_comb begin
    s_awready = '0;
    s_wready  = '0;
    s_arready = '0;
    s_bvalid  = '0;
    s_rvalid  = '0;
    s_bresp   = '0;
    s_rresp   = '0;
    s_rdata   = '0;
    m_awaddr  = '0;
    m_araddr  = '0;
    m_awprot  = '0;
    m_arprot  = '0;
    m_wdata   = '0;
    m_wstrb   = '0;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_arvalid = 1'b0;
    m_bready  = 1'b0;
    m_rready  = 1'b0;
    case (state)
      WR_ADDR: begin
        m_awaddr       = s_awaddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        m_awprot       = s_awprot[gi*3 +: 3];
        m_wdata        = s_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        m_wstrb        = s_wstrb[gi*SW +: SW];
        m_awvalid      = s_awvalid[gnt] & ~aw_done;
        m_wvalid       = s_wvalid[gnt] & ~w_done;
        s_awready[gnt] = m_awready & ~aw_done;
        s_wready[gnt]  = m_wready & ~w_done;
      end
      WR_RESP: begin
        m_bready             = s_bready[gnt];
        s_bvalid[gnt]        = m_bvalid;
        s_bresp[gi*2 +: 2]   = m_bresp;
      end
      RD_ADDR: begin
        m_araddr       = s_araddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        m_arprot       = s_arprot[gi*3 +: 3];
        m_arvalid      = s_arvalid[gnt];
        s_arready[gnt] = m_arready;
      end
      RD_DATA: begin
        m_rready                              = s_rready[gnt];
        s_rvalid[gnt]                         = m_rvalid;
        s_rresp[gi*2 +: 2]                    = m_rresp;
        s_rdata[gi*DATA_WIDTH +: DATA_WIDTH]  = m_rdata;
      end
      default: ;
    endcase
  end
endmodule

// File: doc/axi4_lite_arbiter.md
Name: axi4_lite_arbiter

Overview:
- Two-master to one-slave AXI4-Lite arbiter for the Zybo Z7-20 register fabric.
- Lets two AXI4-Lite masters (e.g. the UART bridge and the debug/test master) share one AXI4-Lite slave port (register block).
- One transaction, read or write, is outstanding at a time.
- Grants are round-robin between masters; within a master, writes take priority over reads.

Parameters:
- NUM_M, 2, number of upstream masters; fixed at 2 for this revision. Vectors below are packed, master i occupies slice i.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8.

Ports:
- aclk  input  1  clock, all logic on rising edge
- aresetn  input  1  asynchronous active-low reset
- s_awaddr, s_araddr  input  NUM_M*ADDR_WIDTH  upstream addresses
- s_awprot, s_arprot  input  NUM_M*3  upstream protection
- s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready  input  NUM_M  upstream valids/readys
- s_wdata  input  NUM_M*DATA_WIDTH  upstream write data
- s_wstrb  input  NUM_M*DATA_WIDTH/8  upstream write strobes
- s_awready, s_wready, s_arready, s_bvalid, s_rvalid  output  NUM_M  upstream handshakes
- s_bresp, s_rresp  output  NUM_M*2  upstream responses
- s_rdata  output  NUM_M*DATA_WIDTH  upstream read data
- m_awaddr, m_araddr  output  ADDR_WIDTH  downstream addresses
- m_awprot, m_arprot  output  3  downstream protection
- m_wdata  output  DATA_WIDTH  downstream write data
- m_wstrb  output  DATA_WIDTH/8  downstream write strobes
- m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready  output  1  downstream handshakes
- m_awready, m_wready, m_arready, m_bvalid, m_rvalid  input  1  downstream handshakes
- m_bresp, m_rresp  input  2  downstream responses
- m_rdata  input  DATA_WIDTH  downstream read data

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; RR pointer selects master 0 as highest priority; grant/type registers cleared; aw_done and w_done cleared.
  - All valid/ready outputs and s_b/rvalid are 0; s_bresp, s_rresp, s_rdata, and m_* payloads are 0.
- States: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA.
- IDLE:
  - Request of master i = s_awvalid[i] | s_arvalid[i].
  - Grant goes to the first requester at or after the RR pointer.
  - Type is WRITE if s_awvalid[granted] is 1, else READ.
  - Grant and type are registered; next state is WR_ADDR or RD_ADDR. Forwarding starts the cycle after the request is seen (1-cycle arbitration latency).
  - No requests: stay in IDLE, all outputs idle.
- WR_ADDR:
  - m_awvalid = s_awvalid[g] & ~aw_done. m_wvalid = s_wvalid[g] & ~w_done.
  - Payloads come from master g; s_awready[g] and s_wready[g] mirror the m_* readys, gated the same way.
  - AW and W complete independently in either order or in the same cycle; each sets its done flag.
  - When both are done: go to WR_RESP.
  - Missing s_wvalid: wait indefinitely (no timeout).
- WR_RESP:
  - m_bready = s_bready[g]; s_bvalid[g] = m_bvalid; s_bresp[g] = m_bresp, unmodified.
  - On the b handshake: IDLE; RR pointer = g+1 mod NUM_M; done flags cleared.
- RD_ADDR: m_arvalid = s_arvalid[g]; s_arready[g] = m_arready. On handshake: RD_DATA.
- RD_DATA:
  - s_rvalid[g] = m_rvalid; s_rdata[g] = m_rdata; s_rresp[g] = m_rresp; m_rready = s_rready[g].
  - On handshake: IDLE; pointer = g+1.
- Non-granted master: all of its ready/valid outputs stay 0 throughout. Its requests stay pending; the arbiter never drops them.
- Response paths are combinational pass-through (0 added latency). Only the IDLE grant decision is registered.
- Reset asserted mid-transaction: immediate return to reset values. The in-flight downstream transaction is abandoned; the slave is reset together with the arbiter.
- Response codes (OKAY/SLVERR/DECERR) pass through unchanged; the arbiter generates no responses.

Test Plan:
- Reset, then master 0 writes awaddr 0x0000_0010, wdata 0xDEADBEEF, wstrb 0xF → m_awvalid high 1 cycle after s_awvalid[0]; slave bresp 2'b00 appears on s_bresp[0]/s_bvalid[0]; s_bvalid[1] stays 0.
- Both masters assert arvalid in the same cycle after reset (araddr 0x04 and 0x08) → master 0 is served first (m_araddr 0x04), then master 1 (0x08). Repeat with a simultaneous pair → order 0 then 1 again, since the pointer has returned to 0.
- Master 1 asserts awvalid and arvalid together → write forwarded first, read after the b handshake.
- Master 0 asserts awvalid with wvalid low for 5 cycles; slave accepts AW in the first cycle → m_awvalid drops after the handshake, m_wvalid stays 0 until s_wvalid[0] rises; WR_RESP is entered only after W completes.
- Slave returns rresp 2'b10, rdata 0x1234_5678 to master 1, with s_rready[1] low 3 cycles → m_rready stays 0 for those cycles; master 1 receives SLVERR and the data unchanged.
- aresetn dropped during RD_DATA → all valid/ready outputs are 0 without waiting for a clock edge; after release, a new master 1 read is granted normally.
